fa: RTL and testbench

Single-bit full-adder slice for the approximate-computing datapath, with exact and approximate addition modes selectable at run time. Inputs are sampled on the clock and results are registered. An optional error monitor compares each approximate result against the exact result and counts mismatches. Multi-bit adders in the DNN multiply-accumulate units are built by chaining `fa` instances.

---
 rtl/fa_pkg.sv | 10 +
 rtl/fa_cell.sv | 40 ++++
 rtl/fa.sv | 86 ++++++++
 tb/tb_fa.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared mode encodings and error-counter sizing for the approximate full-adder slice.
package fa_pkg;
    localparam logic [2:0] FA_MODE_EXACT       = 3'd0;
    localparam logic [2:0] FA_MODE_AMA_INV     = 3'd1;
    localparam logic [2:0] FA_MODE_CPY_A_CARRY = 3'd2;
    localparam logic [2:0] FA_MODE_CPY_AB      = 3'd3;

    localparam int unsigned FA_ERR_CNT_W = 16;
    localparam logic [FA_ERR_CNT_W-1:0] FA_ERR_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/fa_cell.sv
// Combinational core: approximate sum/carry selected by mode, plus exact reference result.
module fa_cell
    import fa_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic [2:0] mode,
    output logic       sum,
    output logic       carry,
    output logic       es,
    output logic       ec
);
    assign es = a ^ b ^ c;
    assign ec = (a & b) | (a & c) | (b & c);

    // Reserved encodings fall through to the exact adder.
    always_comb begin
        sum   = es;
        carry = ec;
        case (mode)
            FA_MODE_AMA_INV: begin
                sum   = ~ec;
                carry = ec;
            end
            FA_MODE_CPY_A_CARRY: begin
                sum   = es;
                carry = a;
            end
            FA_MODE_CPY_AB: begin
                sum   = b;
                carry = a;
            end
            default: begin
                sum   = es;
                carry = ec;
            end
        endcase
    end
endmodule

// File: rtl/fa.sv
// Registered approximate full-adder slice. Define FA_ERR_MON_EN to build the
// approximate-vs-exact error flag and saturating mismatch counter.
module fa
    import fa_pkg::*;
(
    input  logic                    a,
    input  logic                    b,
    input  logic                    c,
    output logic                    sum,
    output logic                    carry,
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic [2:0]              mode,
    input  logic                    clr_cnt,
    output logic                    out_vld,
    output logic                    err,
    output logic [FA_ERR_CNT_W-1:0] err_cnt
);
    logic sum_d, carry_d, es, ec;
    logic sum_q, carry_q, out_vld_q;

    fa_cell u_cell (
        .a     (a),
        .b     (b),
        .c     (c),
        .mode  (mode),
        .sum   (sum_d),
        .carry (carry_d),
        .es    (es),
        .ec    (ec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= 1'b0;
            carry_q   <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= in_vld;
            if (in_vld) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end
    end

    assign sum     = sum_q;
    assign carry   = carry_q;
    assign out_vld = out_vld_q;

`ifdef FA_ERR_MON_EN
    logic                    err_d, err_q;
    logic [FA_ERR_CNT_W-1:0] cnt_d, cnt_q;

    assign err_d = (sum_d != es) | (carry_d != ec);

    // Clear wins over a same-edge increment; the count sticks at its maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt)
            cnt_d = '0;
        else if (in_vld && err_d && (cnt_q != FA_ERR_CNT_MAX))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (in_vld)
                err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = cnt_q;
`else
    logic unused_mon;
    assign unused_mon = ^{clr_cnt, es, ec};
    assign err        = 1'b0;
    assign err_cnt    = '0;
`endif
endmodule

// File: tb/tb_fa.sv
// Directed-vector bench for fa; expectations track FA_ERR_MON_EN when it is defined.
module tb_fa;
`ifdef FA_ERR_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a = 1'b0, b = 1'b0, c = 1'b0;
    logic        in_vld = 1'b0, clr_cnt = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        sum, carry, out_vld, err;
    logic [15:0] err_cnt;

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] exp_cnt = 16'd0;

    fa dut (
        .a(a), .b(b), .c(c), .sum(sum), .carry(carry),
        .clk(clk), .rst(rst), .in_vld(in_vld), .mode(mode), .clr_cnt(clr_cnt),
        .out_vld(out_vld), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [2:0] abc, input logic [2:0] m, input logic v, input logic clr);
        {a, b, c} = abc;
        mode      = m;
        in_vld    = v;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nvec++;
        if ({sum, carry, out_vld, err, err_cnt} !== 19'd0) begin
            nerr++; $display("FAIL reset_init got %b%b%b%b cnt=%h exp all 0", sum, carry, out_vld, err, err_cnt);
        end
        #1 rst = 1'b0;
        apply(3'b111, 3'd0, 1'b1, 1'b0);
        nvec++;
        if ({sum, carry, out_vld} !== 3'b111) begin
            nerr++; $display("FAIL pre_reset got s=%b c=%b v=%b exp 1 1 1", sum, carry, out_vld);
        end
        #1 rst = 1'b1;
        #1;
        nvec++;
        if ({sum, carry, out_vld, err, err_cnt} !== 19'd0) begin
            nerr++; $display("FAIL async_reset got %b%b%b%b cnt=%h exp all 0", sum, carry, out_vld, err, err_cnt);
        end
        #1 rst = 1'b0;
        in_vld = 1'b0;
        exp_cnt = 16'd0;
    endtask

    task automatic test_exact();
        logic [7:0] tbl_s, tbl_c;
        tbl_s = 8'b1001_0110;
        tbl_c = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            apply(3'(i), 3'd0, 1'b1, 1'b0);
            nvec++;
            if (sum !== tbl_s[i] || carry !== tbl_c[i] || out_vld !== 1'b1 || err !== 1'b0) begin
                nerr++;
                $display("FAIL exact_%0d got s=%b c=%b v=%b e=%b exp s=%b c=%b v=1 e=0",
                         i, sum, carry, out_vld, err, tbl_s[i], tbl_c[i]);
            end
        end
        nvec++;
        if (err_cnt !== 16'd0) begin
            nerr++; $display("FAIL exact_cnt got %h exp 0000", err_cnt);
        end
    endtask

    // One directed sample with hand-computed results; ee is the monitor-enabled err.
    task automatic vec(input string nm, input logic [2:0] abc, input logic [2:0] m,
                       input logic es_, input logic ec_, input logic ee);
        apply(abc, m, 1'b1, 1'b0);
        if (MON && ee) exp_cnt++;
        nvec++;
        if (sum !== es_ || carry !== ec_ || out_vld !== 1'b1 || err !== (MON & ee) || err_cnt !== exp_cnt) begin
            nerr++;
            $display("FAIL %s got s=%b c=%b v=%b e=%b cnt=%h exp s=%b c=%b v=1 e=%b cnt=%h",
                     nm, sum, carry, out_vld, err, err_cnt, es_, ec_, MON & ee, exp_cnt);
        end
    endtask

    task automatic test_modes();
        vec("ama_inv_111", 3'b111, 3'd1, 1'b0, 1'b1, 1'b1);
        vec("ama_inv_110", 3'b110, 3'd1, 1'b0, 1'b1, 1'b0);
        vec("cpy_ab_001",  3'b001, 3'd3, 1'b0, 1'b0, 1'b1);
        vec("cpy_ab_101",  3'b101, 3'd3, 1'b0, 1'b1, 1'b0);
        vec("cpy_ac_011",  3'b011, 3'd2, 1'b0, 1'b0, 1'b1);
        vec("cpy_ac_110",  3'b110, 3'd2, 1'b0, 1'b1, 1'b0);
        vec("rsvd5_110",   3'b110, 3'd5, 1'b0, 1'b1, 1'b0);
        vec("rsvd7_100",   3'b100, 3'd7, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        vec("hold_setup", 3'b111, 3'd1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply(3'(i * 3), 3'd0, 1'b0, 1'b0);
            nvec++;
            if (sum !== 1'b0 || carry !== 1'b1 || out_vld !== 1'b0 || err !== MON || err_cnt !== exp_cnt) begin
                nerr++;
                $display("FAIL hold_%0d got s=%b c=%b v=%b e=%b cnt=%h exp s=0 c=1 v=0 e=%b cnt=%h",
                         i, sum, carry, out_vld, err, err_cnt, MON, exp_cnt);
            end
        end
    endtask

    task automatic test_counter();
        if (MON) begin
            apply(3'b000, 3'd0, 1'b0, 1'b1);
            for (int i = 0; i < 65535; i++) apply(3'b111, 3'd1, 1'b1, 1'b0);
            nvec++;
            if (err_cnt !== 16'hFFFF) begin
                nerr++; $display("FAIL cnt_reach_max got %h exp ffff", err_cnt);
            end
            apply(3'b111, 3'd1, 1'b1, 1'b0);
            apply(3'b111, 3'd1, 1'b1, 1'b0);
            nvec++;
            if (err_cnt !== 16'hFFFF || err !== 1'b1) begin
                nerr++; $display("FAIL cnt_saturate got cnt=%h e=%b exp ffff 1", err_cnt, err);
            end
            apply(3'b111, 3'd1, 1'b1, 1'b1);
            nvec++;
            if (err_cnt !== 16'd0 || err !== 1'b1) begin
                nerr++; $display("FAIL cnt_clr_priority got cnt=%h e=%b exp 0000 1", err_cnt, err);
            end
            apply(3'b111, 3'd1, 1'b1, 1'b0);
            nvec++;
            if (err_cnt !== 16'd1) begin
                nerr++; $display("FAIL cnt_after_clr got %h exp 0001", err_cnt);
            end
        end else begin
            for (int i = 0; i < 4; i++) apply(3'b111, 3'd1, 1'b1, i[0]);
            nvec++;
            if (err_cnt !== 16'd0 || err !== 1'b0 || sum !== 1'b0 || carry !== 1'b1) begin
                nerr++; $display("FAIL mon_off got cnt=%h e=%b s=%b c=%b exp 0000 0 0 1", err_cnt, err, sum, carry);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Mode switches every cycle; each sample must use its own mode.
        apply(3'b011, 3'd0, 1'b1, 1'b0);
        nvec++;
        if ({sum, carry} !== 2'b01) begin
            nerr++; $display("FAIL b2b_0 got %b%b exp 01", sum, carry);
        end
        apply(3'b011, 3'd3, 1'b1, 1'b0);
        nvec++;
        if ({sum, carry} !== 2'b10) begin
            nerr++; $display("FAIL b2b_1 got %b%b exp 10", sum, carry);
        end
        apply(3'b000, 3'd1, 1'b1, 1'b0);
        nvec++;
        if ({sum, carry} !== 2'b10) begin
            nerr++; $display("FAIL b2b_2 got %b%b exp 10", sum, carry);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_exact();
        test_modes();
        test_hold();
        test_back_to_back();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
